// File: rtl/i2c_write_sequencer_if.sv
// -----------------------------------------------------------------------------
// i2c_write_sequencer_if
// Bundles the requester side and the byte-engine side of the I2C write
// sequencer.
//   Requester side : Req, ReqAddr, ReqReg, ReqData  -> sequencer
//                    Grant, Done, Error, Busy       <- sequencer
//   Engine side    : TxData, TxStart, TxStop, TxValid, TxAbort <- sequencer
//                    TxReady, TxDone, TxNack                   -> sequencer
// modport master : the sequencer itself
// modport slave  : the environment (requesters + byte engine)
// -----------------------------------------------------------------------------
interface i2c_write_sequencer_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   Req;
    logic [7*NUM_REQ-1:0] ReqAddr;
    logic [8*NUM_REQ-1:0] ReqReg;
    logic [8*NUM_REQ-1:0] ReqData;
    logic [NUM_REQ-1:0]   Grant;
    logic [NUM_REQ-1:0]   Done;
    logic [NUM_REQ-1:0]   Error;
    logic                 Busy;
    logic [7:0]           TxData;
    logic                 TxStart;
    logic                 TxStop;
    logic                 TxValid;
    logic                 TxReady;
    logic                 TxDone;
    logic                 TxNack;
    logic                 TxAbort;

    modport master (
        input  Req, ReqAddr, ReqReg, ReqData, TxReady, TxDone, TxNack,
        output Grant, Done, Error, Busy, TxData, TxStart, TxStop, TxValid, TxAbort
    );

    modport slave (
        output Req, ReqAddr, ReqReg, ReqData, TxReady, TxDone, TxNack,
        input  Grant, Done, Error, Busy, TxData, TxStart, TxStop, TxValid, TxAbort
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_write_sequencer
// Runs complete 3-byte I2C register writes (START, addr+W, reg, data, STOP)
// through one shared byte-level transmitter, arbitrating round-robin between
// NUM_REQ requesters. Reports Done/Error per requester (NACK or timeout).
// Ports:
//   Clock   : system clock, rising edge
//   Reset_n : synchronous active-low reset
//   bus     : i2c_write_sequencer_if.master (requester + byte engine signals)
// -----------------------------------------------------------------------------
module i2c_write_sequencer #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                   Clock,
    input logic                   Reset_n,
    i2c_write_sequencer_if.master bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_W, REG, REG_W, DATA, DATA_W, FINISH
    } state_t;

    state_t             r_state, w_next;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_idx;
    logic [NUM_REQ-1:0] r_grant;
    logic [6:0]         r_addr;
    logic [7:0]         r_reg;
    logic [7:0]         r_data;
    logic               r_ok;
    logic [TW-1:0]      r_tmo;

    // Per-requester views of the packed request fields.
    logic [6:0] w_addr_a [NUM_REQ];
    logic [7:0] w_reg_a  [NUM_REQ];
    logic [7:0] w_data_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_addr_a[g] = bus.ReqAddr[7*g +: 7];
        assign w_reg_a[g]  = bus.ReqReg[8*g +: 8];
        assign w_data_a[g] = bus.ReqData[8*g +: 8];
    end

    // Round-robin pick: first set Req bit at or after r_ptr, wrapping.
    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_cand;
    logic [NUM_REQ-1:0] w_win_oh;

    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_cand   = '0;
        w_win_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.Req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        w_win_oh[w_win] = 1'b1;
    end

    // Engine-facing and requester-facing outputs are decoded from state only,
    // except TxAbort which must yield to a TxDone arriving on the expiry cycle.
    logic [7:0]         w_txdata;
    logic               w_txstart, w_txstop, w_txvalid, w_txabort;
    logic [NUM_REQ-1:0] w_done, w_error;
    logic               w_hs, w_expired, w_in_wait;

    assign w_hs      = w_txvalid && bus.TxReady;
    assign w_expired = (r_tmo == TMO_LAST);
    assign w_in_wait = (r_state == ADDR_W) || (r_state == REG_W) || (r_state == DATA_W);

    always_ff @(posedge Clock) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_txdata  = 8'h00;
        w_txstart = 1'b0;
        w_txstop  = 1'b0;
        w_txvalid = 1'b0;
        w_txabort = 1'b0;
        w_done    = '0;
        w_error   = '0;
        case (r_state)
            IDLE: if (w_found) w_next = ADDR;
            ADDR: begin
                w_txdata  = {r_addr, 1'b0};
                w_txstart = 1'b1;
                w_txvalid = 1'b1;
                if (bus.TxReady) w_next = ADDR_W;
            end
            REG: begin
                w_txdata  = r_reg;
                w_txvalid = 1'b1;
                if (bus.TxReady) w_next = REG_W;
            end
            DATA: begin
                w_txdata  = r_data;
                w_txstop  = 1'b1;
                w_txvalid = 1'b1;
                if (bus.TxReady) w_next = DATA_W;
            end
            ADDR_W, REG_W, DATA_W: begin
                if (bus.TxDone) begin
                    if (bus.TxNack)            w_next = FINISH;
                    else if (r_state == ADDR_W) w_next = REG;
                    else if (r_state == REG_W)  w_next = DATA;
                    else                        w_next = FINISH;
                end else if (w_expired) begin
                    w_txabort = 1'b1;
                    w_next    = FINISH;
                end
            end
            FINISH: begin
                if (r_ok) w_done  = r_grant;
                else      w_error = r_grant;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_addr  <= '0;
            r_reg   <= '0;
            r_data  <= '0;
            r_ok    <= 1'b0;
            r_tmo   <= '0;
        end else begin
            if (w_hs)           r_tmo <= '0;
            else if (w_in_wait) r_tmo <= r_tmo + 1'b1;

            case (r_state)
                IDLE: if (w_found) begin
                    // Snapshot the winner so later input changes cannot
                    // corrupt the write in flight.
                    r_idx   <= w_win;
                    r_grant <= w_win_oh;
                    r_addr  <= w_addr_a[w_win];
                    r_reg   <= w_reg_a[w_win];
                    r_data  <= w_data_a[w_win];
                    r_ok    <= 1'b0;
                end
                DATA_W: if (bus.TxDone && !bus.TxNack) r_ok <= 1'b1;
                FINISH: begin
                    r_ptr   <= (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.TxData  = w_txdata;
    assign bus.TxStart = w_txstart;
    assign bus.TxStop  = w_txstop;
    assign bus.TxValid = w_txvalid;
    assign bus.TxAbort = w_txabort;
    assign bus.Done    = w_done;
    assign bus.Error   = w_error;
    assign bus.Grant   = r_grant;
    assign bus.Busy    = (r_state != IDLE);
endmodule
